uart_tx_arbiter: RTL and testbench

- Shares the single UART transmitter between two byte sources.
- Requester 0 is the RX-echo FIFO; requester 1 is the stopwatch status-report FIFO.
- Pops one byte at a time from the granted FIFO, launches it on the UART TX start/data interface, and waits for tx-done before re-arbitrating.
- Arbitration is round-robin between the two requesters, with a watchdog that recovers from a missing tx-done.

---
 rtl/uart_tx_arbiter.sv | 107 ++++++++++
 tb/tb_uart_tx_arbiter.sv | 285 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_tx_arbiter.sv
// Round-robin arbiter sharing one UART transmitter between two FWFT byte FIFOs.
// Define UART_TX_ARB_FIXED_PRIO_EN to replace round-robin with fixed priority (req0 wins).
module uart_tx_arbiter #(
    parameter int DATA_WIDTH     = 8,
    parameter int TIMEOUT_CYCLES = 200000
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  i_req0_empty,
    input  logic [DATA_WIDTH-1:0] i_req0_data,
    output logic                  o_req0_rd,
    input  logic                  i_req1_empty,
    input  logic [DATA_WIDTH-1:0] i_req1_data,
    output logic                  o_req1_rd,
    output logic                  o_tx_start,
    output logic [DATA_WIDTH-1:0] o_tx_data,
    input  logic                  i_tx_done,
    output logic [1:0]            o_grant,
    output logic                  o_busy,
    output logic                  o_timeout
);

    localparam int CW = $clog2(TIMEOUT_CYCLES);
    localparam logic [CW-1:0] WD_LAST = CW'(TIMEOUT_CYCLES - 1);

    typedef enum logic [1:0] {
        IDLE,
        START,
        WAIT
    } state_t;

    state_t        state;
    logic [CW-1:0] wd;
    logic          req0;
    logic          req1;
    logic          pick0;
    logic          pick1;
`ifndef UART_TX_ARB_FIXED_PRIO_EN
    logic          last;
`endif

    always_comb begin
        req0 = ~i_req0_empty;
        req1 = ~i_req1_empty;
`ifdef UART_TX_ARB_FIXED_PRIO_EN
        pick0 = req0;
`else
        // On contention the requester that did not own the TX last wins.
        pick0 = req0 & (~req1 | last);
`endif
        pick1 = req1 & ~pick0;
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state      <= IDLE;
            wd         <= '0;
            o_req0_rd  <= 1'b0;
            o_req1_rd  <= 1'b0;
            o_tx_start <= 1'b0;
            o_tx_data  <= '0;
            o_grant    <= 2'b00;
            o_busy     <= 1'b0;
            o_timeout  <= 1'b0;
`ifndef UART_TX_ARB_FIXED_PRIO_EN
            last       <= 1'b1;
`endif
        end else begin
            o_req0_rd  <= 1'b0;
            o_req1_rd  <= 1'b0;
            o_tx_start <= 1'b0;
            o_timeout  <= 1'b0;
            unique case (state)
                IDLE: begin
                    if (pick0 | pick1) begin
                        o_tx_data  <= pick0 ? i_req0_data : i_req1_data;
                        o_grant    <= {pick1, pick0};
                        o_req0_rd  <= pick0;
                        o_req1_rd  <= pick1;
                        o_tx_start <= 1'b1;
                        o_busy     <= 1'b1;
                        state      <= START;
                    end
                end
                START: begin
                    wd    <= '0;
                    state <= WAIT;
                end
                WAIT: begin
                    wd <= wd + 1'b1;
                    // A done arriving on the expiry cycle still counts as success.
                    if (i_tx_done || wd == WD_LAST) begin
                        o_timeout <= ~i_tx_done;
`ifndef UART_TX_ARB_FIXED_PRIO_EN
                        last      <= o_grant[1];
`endif
                        o_grant   <= 2'b00;
                        o_busy    <= 1'b0;
                        state     <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Self-checking bench for uart_tx_arbiter: vector table, directed
// watchdog/reset sequences and randomized FIFO traffic against an order model.
module tb_uart_tx_arbiter;

    localparam int DW = 8;
    localparam int TO = 16;
`ifdef UART_TX_ARB_FIXED_PRIO_EN
    localparam bit FP = 1'b1;
`else
    localparam bit FP = 1'b0;
`endif

    logic          clk = 1'b0;
    logic          reset;
    logic          i_req0_empty;
    logic [DW-1:0] i_req0_data;
    logic          o_req0_rd;
    logic          i_req1_empty;
    logic [DW-1:0] i_req1_data;
    logic          o_req1_rd;
    logic          o_tx_start;
    logic [DW-1:0] o_tx_data;
    logic          i_tx_done;
    logic [1:0]    o_grant;
    logic          o_busy;
    logic          o_timeout;

    uart_tx_arbiter #(.DATA_WIDTH(DW), .TIMEOUT_CYCLES(TO)) dut (
        .clk(clk),
        .reset(reset),
        .i_req0_empty(i_req0_empty),
        .i_req0_data(i_req0_data),
        .o_req0_rd(o_req0_rd),
        .i_req1_empty(i_req1_empty),
        .i_req1_data(i_req1_data),
        .o_req1_rd(o_req1_rd),
        .o_tx_start(o_tx_start),
        .o_tx_data(o_tx_data),
        .i_tx_done(i_tx_done),
        .o_grant(o_grant),
        .o_busy(o_busy),
        .o_timeout(o_timeout)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic       rst_n;
        logic       e0;
        logic       e1;
        logic [7:0] d0;
        logic [7:0] d1;
        logic       done;
        logic [14:0] exp;
    } vec_t;

    int checks = 0;
    int failures = 0;
    logic [7:0] q0[$];
    logic [7:0] q1[$];
    int pops0 = 0;
    int pops1 = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    function automatic logic [14:0] mk(input logic st, input logic r0, input logic r1,
                                       input logic [1:0] g, input logic b, input logic t,
                                       input logic [7:0] d);
        return {st, r0, r1, g, b, t, d};
    endfunction

    function automatic logic [14:0] outs();
        return {o_tx_start, o_req0_rd, o_req1_rd, o_grant, o_busy, o_timeout, o_tx_data};
    endfunction

    task automatic drive_q();
        i_req0_empty = (q0.size() == 0);
        i_req0_data  = (q0.size() != 0) ? q0[0] : 8'h00;
        i_req1_empty = (q1.size() == 0);
        i_req1_data  = (q1.size() != 0) ? q1[0] : 8'h00;
    endtask

    // Advance one clock; FIFOs pop when their strobe is seen.
    task automatic etick();
        @(posedge clk);
        #1;
        if (o_req0_rd && q0.size() != 0) begin
            void'(q0.pop_front());
            pops0++;
        end
        if (o_req1_rd && q1.size() != 0) begin
            void'(q1.pop_front());
            pops1++;
        end
        drive_q();
    endtask

    task automatic do_reset();
        reset = 1'b0;
        etick();
        etick();
        reset = 1'b1;
    endtask

    vec_t tbl[13];

    initial begin
        logic [1:0] g5;
        logic [7:0] x5;
        int n;
        int d;
        bit fin;
        int esrc[$];
        logic [7:0] ebyte[$];
        logic [7:0] c0[$];
        logic [7:0] c1[$];
        int last;
        int pk;
        int n0;
        int n1;

        reset = 1'b1;
        i_tx_done = 1'b0;
        i_req0_empty = 1'b1;
        i_req1_empty = 1'b1;
        i_req0_data = 8'h00;
        i_req1_data = 8'h00;

        g5 = FP ? 2'b01 : 2'b10;
        x5 = FP ? 8'h30 : 8'h61;
        tbl[0]  = '{1'b0, 1'b0, 1'b1, 8'h41, 8'h00, 1'b0, mk(0, 0, 0, 2'b00, 0, 0, 8'h00)};
        tbl[1]  = '{1'b1, 1'b0, 1'b1, 8'h41, 8'h00, 1'b1, mk(1, 1, 0, 2'b01, 1, 0, 8'h41)};
        tbl[2]  = '{1'b1, 1'b1, 1'b1, 8'h00, 8'h00, 1'b1, mk(0, 0, 0, 2'b01, 1, 0, 8'h41)};
        tbl[3]  = '{1'b1, 1'b1, 1'b1, 8'h00, 8'h00, 1'b0, mk(0, 0, 0, 2'b01, 1, 0, 8'h41)};
        tbl[4]  = '{1'b1, 1'b1, 1'b1, 8'h00, 8'h00, 1'b1, mk(0, 0, 0, 2'b00, 0, 0, 8'h41)};
        tbl[5]  = '{1'b1, 1'b0, 1'b0, 8'h30, 8'h61, 1'b0,
                    mk(1, FP, !FP, g5, 1, 0, x5)};
        tbl[6]  = '{1'b1, 1'b0, 1'b0, 8'h30, 8'h61, 1'b0, mk(0, 0, 0, g5, 1, 0, x5)};
        tbl[7]  = '{1'b1, 1'b0, 1'b0, 8'h30, 8'h61, 1'b1, mk(0, 0, 0, 2'b00, 0, 0, x5)};
        tbl[8]  = '{1'b1, 1'b0, 1'b0, 8'h30, 8'h61, 1'b0, mk(1, 1, 0, 2'b01, 1, 0, 8'h30)};
        tbl[9]  = '{1'b0, 1'b0, 1'b0, 8'h31, 8'h62, 1'b0, mk(0, 0, 0, 2'b00, 0, 0, 8'h00)};
        tbl[10] = '{1'b1, 1'b0, 1'b0, 8'h31, 8'h62, 1'b0, mk(1, 1, 0, 2'b01, 1, 0, 8'h31)};
        tbl[11] = '{1'b1, 1'b1, 1'b1, 8'h00, 8'h00, 1'b0, mk(0, 0, 0, 2'b01, 1, 0, 8'h31)};
        tbl[12] = '{1'b1, 1'b1, 1'b1, 8'h00, 8'h00, 1'b1, mk(0, 0, 0, 2'b00, 0, 0, 8'h31)};

        for (int i = 0; i < 13; i++) begin
            reset        = tbl[i].rst_n;
            i_req0_empty = tbl[i].e0;
            i_req1_empty = tbl[i].e1;
            i_req0_data  = tbl[i].d0;
            i_req1_data  = tbl[i].d1;
            i_tx_done    = tbl[i].done;
            @(posedge clk);
            #1;
            chk($sformatf("vec%0d", i), 32'(outs()), 32'(tbl[i].exp));
        end
        i_tx_done = 1'b0;

        // Watchdog: req1 byte, no done ever.
        q0.delete();
        q1.delete();
        q1.push_back(8'h55);
        drive_q();
        do_reset();
        pops1 = 0;
        etick();
        chk("wd_start", 32'(outs()), 32'(mk(1, 0, 1, 2'b10, 1, 0, 8'h55)));
        etick();
        n = 0;
        while (!o_timeout && n < 40) begin
            etick();
            n++;
        end
        chk("wd_latency", n, TO);
        chk("wd_idle", {o_busy, o_grant}, 3'b000);
        etick();
        chk("wd_pulse_len", o_timeout, 1'b0);
        etick();
        chk("wd_pops", pops1, 1);

        // Done on the expiry cycle beats the watchdog.
        q0.push_back(8'hA1);
        drive_q();
        etick();
        chk("co_start", 32'(outs()), 32'(mk(1, 1, 0, 2'b01, 1, 0, 8'hA1)));
        repeat (16) etick();
        chk("co_busy", o_busy, 1'b1);
        i_tx_done = 1'b1;
        etick();
        i_tx_done = 1'b0;
        chk("co_no_timeout", {o_timeout, o_busy, o_grant}, 4'b0000);

        // Reset during WAIT, then req0 wins first.
        q1.push_back(8'h77);
        drive_q();
        etick();
        chk("rw_start", 32'(outs()), 32'(mk(1, 0, 1, 2'b10, 1, 0, 8'h77)));
        etick();
        q0.push_back(8'h10);
        drive_q();
        reset = 1'b0;
        etick();
        chk("rw_zero", 32'(outs()), 32'h0);
        reset = 1'b1;
        q1.push_back(8'h78);
        drive_q();
        etick();
        chk("rw_first", 32'(outs()), 32'(mk(1, 1, 0, 2'b01, 1, 0, 8'h10)));
        etick();
        i_tx_done = 1'b1;
        etick();
        i_tx_done = 1'b0;

        // Randomized rounds against a transaction-order model.
        for (int r = 0; r < 6; r++) begin
            q0.delete();
            q1.delete();
            n0 = $urandom_range(0, 5);
            n1 = $urandom_range(0, 5);
            for (int k = 0; k < n0; k++) q0.push_back(8'($urandom));
            for (int k = 0; k < n1; k++) q1.push_back(8'($urandom));
            c0 = q0;
            c1 = q1;
            esrc.delete();
            ebyte.delete();
            last = 1;
            while (c0.size() != 0 || c1.size() != 0) begin
                if (c0.size() != 0 && c1.size() != 0)
                    pk = FP ? 0 : (last == 1 ? 0 : 1);
                else
                    pk = (c0.size() != 0) ? 0 : 1;
                esrc.push_back(pk);
                ebyte.push_back(pk == 0 ? c0.pop_front() : c1.pop_front());
                last = pk;
            end
            drive_q();
            do_reset();
            pops0 = 0;
            pops1 = 0;
            for (int k = 0; k < esrc.size(); k++) begin
                i_tx_done = ($urandom_range(0, 3) == 0);
                etick();
                i_tx_done = 1'b0;
                chk($sformatf("rnd%0d_%0d_start", r, k), 32'(outs()),
                    32'(mk(1, esrc[k] == 0, esrc[k] == 1,
                           esrc[k] == 0 ? 2'b01 : 2'b10, 1, 0, ebyte[k])));
                i_tx_done = 1'($urandom_range(0, 1));
                etick();
                i_tx_done = 1'b0;
                chk("rnd_busy", {o_busy, o_tx_start}, 2'b10);
                d = $urandom_range(0, 19);
                fin = 1'b0;
                for (int j = 0; j < TO && !fin; j++) begin
                    if (j == d) begin
                        i_tx_done = 1'b1;
                        etick();
                        i_tx_done = 1'b0;
                        chk("rnd_done", {o_timeout, o_busy, o_grant}, 4'b0000);
                        fin = 1'b1;
                    end else begin
                        etick();
                        if (j == TO - 1) begin
                            chk("rnd_timeout", {o_timeout, o_busy, o_grant}, 4'b1000);
                            fin = 1'b1;
                        end
                    end
                end
                chk("rnd_hold", o_tx_data, ebyte[k]);
            end
            etick();
            chk("rnd_quiet", {o_tx_start, o_busy}, 2'b00);
            chk("rnd_pops", {16'(pops0), 16'(pops1)}, {16'(n0), 16'(n1)});
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
